// File: rtl/fifo_sync_prog_if.sv
// Producer/consumer bundle for fifo_sync_prog: write/read handshake, thresholds and status.
// master = user side (producer, consumer or bench), slave = the FIFO itself.
interface fifo_sync_prog_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 4
);
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic [CNT_W-1:0]      af_thresh;
    logic [CNT_W-1:0]      ae_thresh;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;

    modport master (
        output wr_en, rd_en, data_in, af_thresh, ae_thresh,
        input  data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  wr_en, rd_en, data_in, af_thresh, ae_thresh,
        output data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty thresholds,
// occupancy count and optional first-word-fall-through read port.
module fifo_sync_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_prog_if.slave  bus
);
    localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full, empty, wr_acc, rd_acc;

    // Flags come from the registered count only, so there is no path from wr_en/rd_en.
    assign full   = (count_q == CNT_MAX);
    assign empty  = (count_q == '0);
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_acc;
        overflow_d  = bus.wr_en && !wr_acc;
        underflow_d = bus.rd_en && !rd_acc;
        if (wr_acc)
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (rd_acc)
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the count guarantees stale words are never read.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [FIFO_WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_acc)
                    dout_d = mem_q[rd_ptr_q];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else        dout_q <= dout_d;
            end

            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count_q >= bus.af_thresh);
    assign bus.almostempty = (count_q <= bus.ae_thresh);
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog: depth-8 registered, depth-5 wrap and depth-8 FWFT instances.
module tb_fifo_sync_prog;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fifo_sync_prog_if #(.FIFO_WIDTH(16), .CNT_W(4)) b8 ();
    fifo_sync_prog_if #(.FIFO_WIDTH(16), .CNT_W(3)) b5 ();
    fifo_sync_prog_if #(.FIFO_WIDTH(16), .CNT_W(4)) bf ();

    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_d5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fw (.clk(clk), .rst_n(rst_n), .bus(bf.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the active edge, inputs changed at the same point.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] drain_exp [8];

    initial begin
        rst_n = 1'b0;
        b8.wr_en = 0; b8.rd_en = 0; b8.data_in = '0; b8.af_thresh = 4'd6; b8.ae_thresh = 4'd2;
        b5.wr_en = 0; b5.rd_en = 0; b5.data_in = '0; b5.af_thresh = 3'd4; b5.ae_thresh = 3'd1;
        bf.wr_en = 0; bf.rd_en = 0; bf.data_in = '0; bf.af_thresh = 4'd6; bf.ae_thresh = 4'd2;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset / idle state
        chk("rst_count", 32'(b8.count), 0);
        chk("rst_empty", 32'(b8.empty), 1);
        chk("rst_aempty", 32'(b8.almostempty), 1);
        chk("rst_full", 32'(b8.full), 0);
        chk("rst_afull", 32'(b8.almostfull), 0);
        chk("rst_dout", 32'(b8.data_out), 0);
        chk("rst_pulses", 32'({b8.wr_ack, b8.overflow, b8.underflow}), 0);

        // Fill depth-8 FIFO
        for (int i = 1; i <= 8; i++) begin
            b8.wr_en = 1; b8.data_in = 16'(i);
            tick();
            chk("fill_ack", 32'(b8.wr_ack), 1);
            chk("fill_count", 32'(b8.count), 32'(i));
            chk("fill_afull", 32'(b8.almostfull), (i >= 6) ? 1 : 0);
            chk("fill_aempty", 32'(b8.almostempty), (i <= 2) ? 1 : 0);
            chk("fill_full", 32'(b8.full), (i == 8) ? 1 : 0);
        end
        b8.data_in = 16'h0009;
        tick();
        chk("ovf_pulse", 32'(b8.overflow), 1);
        chk("ovf_ack", 32'(b8.wr_ack), 0);
        chk("ovf_count", 32'(b8.count), 8);
        b8.wr_en = 0;
        tick();
        chk("ovf_clear", 32'(b8.overflow), 0);

        // Simultaneous read/write while full
        b8.wr_en = 1; b8.rd_en = 1; b8.data_in = 16'hAAAA;
        tick();
        chk("rw_full_dout", 32'(b8.data_out), 32'h0001);
        chk("rw_full_count", 32'(b8.count), 8);
        chk("rw_full_ovf", 32'(b8.overflow), 0);
        chk("rw_full_ack", 32'(b8.wr_ack), 1);

        // Drain in order
        b8.wr_en = 0;
        for (int k = 0; k < 7; k++) drain_exp[k] = 16'(k + 2);
        drain_exp[7] = 16'hAAAA;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("drain_dout", 32'(b8.data_out), 32'(drain_exp[k]));
            chk("drain_count", 32'(b8.count), 32'(7 - k));
        end
        chk("drain_empty", 32'(b8.empty), 1);

        // Read from empty
        tick();
        chk("udf_pulse", 32'(b8.underflow), 1);
        chk("udf_dout_hold", 32'(b8.data_out), 32'hAAAA);
        chk("udf_count", 32'(b8.count), 0);

        // Write + read on empty: write wins, read underflows
        b8.wr_en = 1; b8.data_in = 16'h1234;
        tick();
        chk("wr_empty_ack", 32'(b8.wr_ack), 1);
        chk("wr_empty_udf", 32'(b8.underflow), 1);
        chk("wr_empty_count", 32'(b8.count), 1);
        b8.wr_en = 0; b8.rd_en = 0;
        tick();
        chk("pulses_clear", 32'({b8.wr_ack, b8.overflow, b8.underflow}), 0);
        chk("dout_hold", 32'(b8.data_out), 32'hAAAA);

        // Depth-5 wrap: three rounds of 5 writes / 5 reads
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 5; j++) begin
                b5.wr_en = 1; b5.data_in = 16'(16'h0100 * (r + 1) + j);
                tick();
                chk("d5_wr_count", 32'(b5.count), 32'(j + 1));
            end
            b5.wr_en = 0;
            chk("d5_full", 32'(b5.full), 1);
            b5.wr_en = 1; b5.data_in = 16'hDEAD;
            tick();
            chk("d5_ovf", 32'(b5.overflow), 1);
            b5.wr_en = 0;
            b5.rd_en = 1;
            for (int j = 0; j < 5; j++) begin
                tick();
                chk("d5_rd_data", 32'(b5.data_out), 32'(16'h0100 * (r + 1) + j));
                chk("d5_rd_count", 32'(b5.count), 32'(4 - j));
            end
            b5.rd_en = 0;
            chk("d5_empty", 32'(b5.empty), 1);
        end
        // af_thresh = 0 forces almostfull even when empty
        b5.af_thresh = 3'd0;
        #1;
        chk("d5_af_zero", 32'(b5.almostfull), 1);

        // FWFT
        chk("fw_dout_empty", 32'(bf.data_out), 0);
        bf.wr_en = 1; bf.data_in = 16'hBEEF;
        tick();
        bf.wr_en = 0;
        chk("fw_dout_beef", 32'(bf.data_out), 32'hBEEF);
        chk("fw_count1", 32'(bf.count), 1);
        tick();
        chk("fw_hold", 32'(bf.data_out), 32'hBEEF);
        bf.rd_en = 1;
        tick();
        bf.rd_en = 0;
        chk("fw_pop_count", 32'(bf.count), 0);
        chk("fw_pop_dout", 32'(bf.data_out), 0);
        for (int j = 1; j <= 3; j++) begin
            bf.wr_en = 1; bf.data_in = 16'(16'h0011 * j);
            tick();
        end
        bf.wr_en = 0;
        chk("fw_count3", 32'(bf.count), 3);
        chk("fw_head", 32'(bf.data_out), 32'h0011);
        chk("fw_af_before", 32'(bf.almostfull), 0);
        bf.af_thresh = 4'd2;
        #1;
        chk("fw_af_same_cycle", 32'(bf.almostfull), 1);
        bf.rd_en = 1;
        tick();
        bf.rd_en = 0;
        chk("fw_next_word", 32'(bf.data_out), 32'h0022);
        chk("fw_count2", 32'(bf.count), 2);

        // Mid-operation reset: everything empties immediately
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count8", 32'(b8.count), 0);
        chk("mid_rst_dout8", 32'(b8.data_out), 0);
        chk("mid_rst_countf", 32'(bf.count), 0);
        chk("mid_rst_doutf", 32'(bf.data_out), 0);
        chk("mid_rst_emptyf", 32'(bf.empty), 1);
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst_doutf", 32'(bf.data_out), 0);
        chk("post_rst_pulses", 32'({b8.wr_ack, b8.overflow, b8.underflow}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
